// File: rtl/mem_pkg.sv
// Shared definitions for the word-to-byte memory access controller:
// FSM state encoding, word geometry and the byte-counter type.
package mem_pkg;

    // Controller states. IDLE accepts requests, WRITE/READ stream the
    // four bytes, DONE presents the completion pulse for one cycle.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int BYTES_PER_WORD = 4;

    // The counter must reach BYTES_PER_WORD (one extra load cycle to
    // capture the last byte), so it is one bit wider than the byte index.
    localparam int CNT_W = $clog2(BYTES_PER_WORD) + 1;

    typedef logic [CNT_W-1:0] cnt_t;

    // Index of the last byte strobe.
    localparam cnt_t CNT_LAST = cnt_t'(BYTES_PER_WORD - 1);
    // Load-only tail cycle in which the last read byte arrives.
    localparam cnt_t CNT_TAIL = cnt_t'(BYTES_PER_WORD);

    // Little-endian byte lane select of a 32-bit word.
    function automatic logic [7:0] word_byte(input logic [31:0] word,
                                             input logic [1:0]  idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/mem_access_ctrl.sv
// Converts single-cycle 32-bit CPU loads/stores into four sequential
// byte accesses on a byte-wide memory. Byte 0 goes to the lowest address.
// All memory-side outputs, done_o, misalign_o and req_rdata_o are flops;
// only stall_o is combinational because the CPU must freeze in the same
// cycle that it presents an acceptable request.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [31:0]           req_wdata_i,
    input  logic                  req_read_i,
    input  logic                  req_write_i,
    output logic [31:0]           req_rdata_o,
    output logic                  stall_o,
    output logic                  done_o,
    output logic                  misalign_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [7:0]            mem_wdata_o,
    output logic                  mem_read_o,
    output logic                  mem_write_o,
    input  logic [7:0]            mem_rdata_i
);

    // FSM and datapath state
    state_e                r_state;
    state_e                w_state_next;
    cnt_t                  r_cnt;
    cnt_t                  w_cnt_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] w_addr_next;
    logic [31:0]           r_wdata;
    logic [31:0]           w_wdata_next;
    logic [31:0]           r_rbuf;
    logic [31:0]           w_rbuf_next;

    // Registered outputs
    logic [31:0]           r_rdata;
    logic [31:0]           w_rdata_next;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [ADDR_WIDTH-1:0] w_mem_addr_next;
    logic [7:0]            r_mem_wdata;
    logic [7:0]            w_mem_wdata_next;
    logic                  r_mem_read;
    logic                  w_mem_read_next;
    logic                  r_mem_write;
    logic                  w_mem_write_next;
    logic                  r_done;
    logic                  w_done_next;
    logic                  r_misalign;
    logic                  w_misalign_next;

    // Request decode and counter-derived helpers
    logic                  w_req;
    logic                  w_aligned;
    cnt_t                  w_cnt_inc;
    logic [ADDR_WIDTH-1:0] w_addr_inc;
    logic [1:0]            w_cap_idx;

    assign w_req     = req_read_i | req_write_i;
    assign w_aligned = (req_addr_i[1:0] == 2'b00);
    assign w_cnt_inc = r_cnt + cnt_t'(1);
    // Address of the next strobe; wraps modulo 2^ADDR_WIDTH by width alone.
    assign w_addr_inc = r_addr + ADDR_WIDTH'(w_cnt_inc);
    // Read data lags its strobe by one cycle, so counter k captures byte k-1.
    assign w_cap_idx = r_cnt[1:0] - 2'd1;

    // Stall is held low throughout reset, even with a request pending.
    assign stall_o = rst_i &
                     (((r_state == ST_IDLE) && w_req && w_aligned) ||
                      (r_state == ST_WRITE) || (r_state == ST_READ));

    assign req_rdata_o = r_rdata;
    assign done_o      = r_done;
    assign misalign_o  = r_misalign;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;
    assign mem_read_o  = r_mem_read;
    assign mem_write_o = r_mem_write;

    // State register
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and next-output logic for every registered signal
    always_comb begin
        // NOTE: every target gets a default before the case statement so no
        // path can leave a variable unassigned and infer a latch.
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_addr_next      = r_addr;
        w_wdata_next     = r_wdata;
        w_rbuf_next      = r_rbuf;
        w_rdata_next     = r_rdata;
        w_mem_addr_next  = r_mem_addr;
        w_mem_wdata_next = r_mem_wdata;
        w_mem_read_next  = 1'b0;
        w_mem_write_next = 1'b0;
        w_done_next      = 1'b0;
        w_misalign_next  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_req && w_aligned) begin
                    // Latch the request; byte 0 is issued on the accept edge.
                    w_addr_next     = req_addr_i;
                    w_wdata_next    = req_wdata_i;
                    w_cnt_next      = '0;
                    w_mem_addr_next = req_addr_i;
                    if (req_write_i) begin
                        // A store wins when both request lines are high.
                        w_state_next     = ST_WRITE;
                        w_mem_write_next = 1'b1;
                        w_mem_wdata_next = req_wdata_i[7:0];
                    end else begin
                        w_state_next    = ST_READ;
                        w_mem_read_next = 1'b1;
                    end
                end else if (w_req) begin
                    w_misalign_next = 1'b1;
                end
            end

            ST_WRITE: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_next = ST_DONE;
                    w_done_next  = 1'b1;
                end else begin
                    w_cnt_next       = w_cnt_inc;
                    w_mem_write_next = 1'b1;
                    w_mem_addr_next  = w_addr_inc;
                    w_mem_wdata_next = word_byte(r_wdata, w_cnt_inc[1:0]);
                end
            end

            ST_READ: begin
                if (r_cnt == CNT_TAIL) begin
                    // Last byte goes straight into the result register.
                    w_state_next = ST_DONE;
                    w_done_next  = 1'b1;
                    w_rdata_next = {mem_rdata_i, r_rbuf[23:0]};
                end else begin
                    if (r_cnt != '0) begin
                        w_rbuf_next[{w_cap_idx, 3'b000} +: 8] = mem_rdata_i;
                    end
                    w_cnt_next = w_cnt_inc;
                    if (r_cnt != CNT_LAST) begin
                        w_mem_read_next = 1'b1;
                        w_mem_addr_next = w_addr_inc;
                    end
                end
            end

            ST_DONE: begin
                // Any request seen here is ignored; it is re-evaluated in IDLE.
                w_state_next = ST_IDLE;
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath and registered outputs
    // NOTE: every register here is a small flop (no memory array), so all
    // of them are reset; an asynchronous reset also kills strobes mid-transfer.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt       <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rbuf      <= '0;
            r_rdata     <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_done      <= 1'b0;
            r_misalign  <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_next;
            r_addr      <= w_addr_next;
            r_wdata     <= w_wdata_next;
            r_rbuf      <= w_rbuf_next;
            r_rdata     <= w_rdata_next;
            r_mem_addr  <= w_mem_addr_next;
            r_mem_wdata <= w_mem_wdata_next;
            r_mem_read  <= w_mem_read_next;
            r_mem_write <= w_mem_write_next;
            r_done      <= w_done_next;
            r_misalign  <= w_misalign_next;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: a byte-wide memory model on the
// memory side and a word-level reference memory for expected results.
module tb_mem_access_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] req_addr_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic        req_read_i = 1'b0;
    logic        req_write_i = 1'b0;
    logic [31:0] req_rdata_o;
    logic        stall_o;
    logic        done_o;
    logic        misalign_o;
    logic [31:0] mem_addr_o;
    logic [7:0]  mem_wdata_o;
    logic        mem_read_o;
    logic        mem_write_o;
    logic [7:0]  mem_rdata_i = '0;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    logic [31:0] last_rdata = '0;

    mem_access_ctrl #(.ADDR_WIDTH(32)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .req_read_i  (req_read_i),
        .req_write_i (req_write_i),
        .req_rdata_o (req_rdata_o),
        .stall_o     (stall_o),
        .done_o      (done_o),
        .misalign_o  (misalign_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_read_o  (mem_read_o),
        .mem_write_o (mem_write_o),
        .mem_rdata_i (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Byte memory seen by the DUT; unwritten locations hold a pattern.
    logic [7:0] mem     [logic [31:0]];
    // Word-level reference memory updated per completed transaction.
    logic [7:0] ref_mem [logic [31:0]];

    function automatic logic [7:0] fill_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] env_byte(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : fill_byte(a);
    endfunction

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : fill_byte(a);
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        return {ref_byte(a + 32'd3), ref_byte(a + 32'd2),
                ref_byte(a + 32'd1), ref_byte(a)};
    endfunction

    // Memory model: writes on the strobe edge, read data valid one cycle later.
    always @(posedge clk_i) begin
        if (mem_write_o) mem[mem_addr_o] = mem_wdata_o;
        if (mem_read_o) mem_rdata_i <= env_byte(mem_addr_o);
        else            mem_rdata_i <= 8'($urandom);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            pass_cnt++;
    endtask

    // One CPU request, checked against the word-level rules.
    task automatic do_req(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic rd, input logic wr);
        int          done_at;
        int          nwr;
        int          nrd;
        logic        bad;
        logic [31:0] got_rdata;
        logic [31:0] exp_rdata;
        @(negedge clk_i);
        req_addr_i  = addr;
        req_wdata_i = wdata;
        req_read_i  = rd;
        req_write_i = wr;
        #1;
        if (addr[1:0] != 2'b00) begin
            check("stall_unaligned", 32'(stall_o), 0);
            @(negedge clk_i);
            req_read_i  = 1'b0;
            req_write_i = 1'b0;
            check("misalign_pulse", 32'(misalign_o), 1);
            check("misalign_no_strobe", 32'({mem_read_o, mem_write_o}), 0);
            @(negedge clk_i);
            check("misalign_one_cycle", 32'(misalign_o), 0);
            check("misalign_no_strobe2", 32'({mem_read_o, mem_write_o}), 0);
            return;
        end
        check("stall_accept", 32'(stall_o), 1);
        done_at   = 0;
        nwr       = 0;
        nrd       = 0;
        bad       = 1'b0;
        got_rdata = '0;
        for (int n = 1; n <= 12 && done_at == 0; n++) begin
            @(negedge clk_i);
            if (n == 1) begin
                // Latched copies must be used; scramble the live inputs.
                req_addr_i  = $urandom;
                req_wdata_i = $urandom;
            end
            if (mem_read_o && mem_write_o) bad = 1'b1;
            if (mem_write_o) begin
                if (!wr || nwr > 3 || n != nwr + 1 ||
                    mem_addr_o != addr + 32'(nwr) ||
                    mem_wdata_o != 8'(wdata >> (8 * nwr))) bad = 1'b1;
                nwr++;
            end
            if (mem_read_o) begin
                if (wr || nrd > 3 || n != nrd + 1 ||
                    mem_addr_o != addr + 32'(nrd)) bad = 1'b1;
                nrd++;
            end
            if (done_o) begin
                done_at   = n;
                got_rdata = req_rdata_o;
                check("stall_in_done", 32'(stall_o), 0);
                // A request presented during DONE must be ignored.
                req_addr_i  = 32'h300 + {$urandom_range(0, 15), 2'b00};
                req_wdata_i = $urandom;
                req_write_i = 1'b1;
                req_read_i  = 1'b0;
            end
        end
        if (wr) begin
            check("store_latency", 32'(done_at), 5);
            check("store_strobes", 32'(nwr), 4);
            check("store_no_reads", 32'(nrd), 0);
            exp_rdata = last_rdata;
            for (int k = 0; k < 4; k++)
                ref_mem[addr + 32'(k)] = wdata[8 * k +: 8];
        end else begin
            check("load_latency", 32'(done_at), 6);
            check("load_strobes", 32'(nrd), 4);
            check("load_no_writes", 32'(nwr), 0);
            exp_rdata  = ref_word(addr);
            last_rdata = exp_rdata;
        end
        check("strobe_sequence_ok", 32'(bad), 0);
        check("rdata_at_done", got_rdata, exp_rdata);
        @(negedge clk_i);
        req_read_i  = 1'b0;
        req_write_i = 1'b0;
        #1;
        check("done_one_cycle", 32'(done_o), 0);
        check("done_req_ignored", 32'({mem_read_o, mem_write_o}), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic        rd;
        logic        wr;
        int          r;
        // Reset state
        #2 rst_i = 1'b0;
        #1;
        check("rst_stall", 32'(stall_o), 0);
        check("rst_done", 32'(done_o), 0);
        check("rst_misalign", 32'(misalign_o), 0);
        check("rst_strobes", 32'({mem_read_o, mem_write_o}), 0);
        check("rst_mem_addr", mem_addr_o, 0);
        check("rst_mem_wdata", 32'(mem_wdata_o), 0);
        check("rst_rdata", req_rdata_o, 0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;

        // Directed cases
        do_req(32'h10, 32'hDEADBEEF, 1'b0, 1'b1);
        check("st10_b0", 32'(env_byte(32'h10)), 32'hEF);
        check("st10_b3", 32'(env_byte(32'h13)), 32'hDE);
        do_req(32'h10, 32'h0, 1'b1, 1'b0);
        check("ld10_word", req_rdata_o, 32'hDEADBEEF);
        do_req(32'h11, 32'h0, 1'b1, 1'b0);
        do_req(32'h20, 32'h01020304, 1'b1, 1'b1);
        check("both_b0", 32'(env_byte(32'h20)), 32'h04);
        check("both_b3", 32'(env_byte(32'h23)), 32'h01);
        do_req(32'hFFFFFFFC, 32'hA1B2C3D4, 1'b0, 1'b1);
        check("top_no_wrap", 32'(env_byte(32'h0)), 32'(fill_byte(32'h0)));
        do_req(32'hFFFFFFFC, 32'h0, 1'b1, 1'b0);
        check("ld_top_word", req_rdata_o, 32'hA1B2C3D4);

        // Reset while byte 2 of a store is on the bus
        @(negedge clk_i);
        req_addr_i  = 32'h40;
        req_wdata_i = 32'hCAFEF00D;
        req_write_i = 1'b1;
        repeat (3) @(negedge clk_i);
        check("abort_pre_addr", mem_addr_o, 32'h42);
        check("abort_pre_strobe", 32'(mem_write_o), 1);
        rst_i = 1'b0;
        #1;
        check("abort_strobe_drop", 32'({mem_read_o, mem_write_o}), 0);
        check("abort_stall", 32'(stall_o), 0);
        check("abort_mem_addr", mem_addr_o, 0);
        check("abort_rdata", req_rdata_o, 0);
        req_write_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        ref_mem[32'h40] = 8'h0D;
        ref_mem[32'h41] = 8'hF0;
        last_rdata = '0;
        for (int k = 0; k < 4; k++)
            check("abort_mem_byte", 32'(env_byte(32'h40 + 32'(k))),
                  32'(ref_byte(32'h40 + 32'(k))));
        do_req(32'h40, 32'h0, 1'b1, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      a = $urandom | 32'h1;
            else if (r == 1) a = 32'hFFFFFFF0 + {28'($urandom_range(0, 3)), 2'b00};
            else             a = 32'h100 + {28'($urandom_range(0, 7)), 2'b00};
            d  = $urandom;
            rd = 1'($urandom);
            wr = 1'($urandom);
            if (!rd && !wr) rd = 1'b1;
            do_req(a, d, rd, wr);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
